// File: rtl/fxp_mac_stream.sv
// Streaming fixed-point dot-product engine with fused ReLU on the result.
// Optional FXP_MAC_SAT_EN: saturating product and accumulate instead of wrapping.
module fxp_mac_stream #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_d,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             stall;
  logic [PW-1:0]    a_ext, b_ext, z;
  logic [WIDTH-1:0] p;
  logic             unused_z;

  logic             s1_valid_q, s1_last_q;
  logic [WIDTH-1:0] s1_p_q;
  logic             first_q;
  logic [WIDTH-1:0] acc_q, acc_base, acc_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic             sum_pos;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Sign-extend first so the truncated PW-bit product is the exact signed result.
  assign a_ext = {{WIDTH{in_a[WIDTH-1]}}, in_a};
  assign b_ext = {{WIDTH{in_b[WIDTH-1]}}, in_b};
  assign z     = a_ext * b_ext;

`ifdef FXP_MAC_SAT_EN
  localparam logic [WIDTH-1:0] MaxVal = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  logic             z_fits;
  logic [WIDTH-1:0] sum_raw;
  logic             add_ovf;

  // The product fits when every bit above the kept sign position matches it.
  assign z_fits   = (&z[PW-1:WIDTH+FRAC-1]) || !(|z[PW-1:WIDTH+FRAC-1]);
  assign p        = z_fits ? {z[PW-1], z[WIDTH+FRAC-2:FRAC]} : (z[PW-1] ? MinVal : MaxVal);
  assign unused_z = ^z[FRAC-1:0];

  assign sum_raw  = acc_base + s1_p_q;
  assign add_ovf  = (acc_base[WIDTH-1] == s1_p_q[WIDTH-1]) &&
                    (sum_raw[WIDTH-1] != acc_base[WIDTH-1]);
  assign acc_next = add_ovf ? (acc_base[WIDTH-1] ? MinVal : MaxVal) : sum_raw;
`else
  assign p        = {z[PW-1], z[WIDTH+FRAC-2:FRAC]};
  assign unused_z = ^{z[PW-2:WIDTH+FRAC-1], z[FRAC-1:0]};
  assign acc_next = acc_base + s1_p_q;
`endif

  assign acc_base = first_q ? '0 : acc_q;
  assign cnt_next = first_q ? CntOne : ((&cnt_q) ? cnt_q : cnt_q + CntOne);
  assign sum_pos  = !acc_next[WIDTH-1] && (|acc_next);

  // Product stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_p_q     <= '0;
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      s1_last_q  <= in_last;
      s1_p_q     <= p;
    end
  end

  // Accumulate and output stage; when not stalled any pending result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q   <= 1'b1;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_d     <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
    end else if (!stall) begin
      out_valid <= 1'b0;
      if (s1_valid_q) begin
        if (s1_last_q) begin
          out_valid <= 1'b1;
          out_sum   <= acc_next;
          out_y     <= sum_pos ? acc_next : '0;
          out_d     <= sum_pos;
          out_count <= cnt_next;
          first_q   <= 1'b1;
          acc_q     <= '0;
          cnt_q     <= '0;
        end else begin
          first_q <= 1'b0;
          acc_q   <= acc_next;
          cnt_q   <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_fxp_mac_stream.sv
// Directed self-checking bench for fxp_mac_stream with default parameters.
// Expected values follow FXP_MAC_SAT_EN when the bench is built with it.
module tb_fxp_mac_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready, out_d;
  logic [31:0] out_y, out_sum;
  logic [7:0]  out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fxp_mac_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_d    (out_d),
    .out_sum  (out_sum),
    .out_count(out_count)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Present one beat (called #1 after an edge), hold until accepted, return #1 after acceptance.
  task automatic drive_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    int n = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!in_ready) begin
      errors++; $display("FAIL beat_accept: got in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    ok = out_valid;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL out_timeout: got out_valid=%b want 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_y, out_d, out_sum, out_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b y=%h d=%b s=%h c=%h want all 0",
               out_valid, out_y, out_d, out_sum, out_count);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    drive_beat(32'h0001_8000, 32'h0002_0000, 1'b0);
    drive_beat(32'hFFFF_0000, 32'h0004_0000, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_latency_early: got out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL basic_latency: got out_valid=%b want 1", out_valid);
    end
    checks++;
    if (out_sum !== 32'hFFFF_0000 || out_y !== 32'h0 || out_d !== 1'b0 || out_count !== 8'd2) begin
      errors++;
      $display("FAIL basic_payload: got s=%h y=%h d=%b c=%0d want s=ffff0000 y=0 d=0 c=2",
               out_sum, out_y, out_d, out_count);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_consume: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_single();
    bit ok;
    drive_beat(32'h0001_8000, 32'h0002_0000, 1'b1);
    wait_out(ok);
    checks++;
    if (out_sum !== 32'h0003_0000 || out_y !== 32'h0003_0000 || out_d !== 1'b1 ||
        out_count !== 8'd1) begin
      errors++;
      $display("FAIL single_payload: got s=%h y=%h d=%b c=%0d want s=y=00030000 d=1 c=1",
               out_sum, out_y, out_d, out_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    bit ok;
    drive_beat(32'h0000_0000, 32'h0001_2345, 1'b1);
    wait_out(ok);
    checks++;
    if (out_sum !== 32'h0 || out_y !== 32'h0 || out_d !== 1'b0 || out_count !== 8'd1) begin
      errors++;
      $display("FAIL zero_sum: got s=%h y=%h d=%b c=%0d want 0 0 0 1",
               out_sum, out_y, out_d, out_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_product_overflow();
    bit ok;
    logic [31:0] exp_s;
`ifdef FXP_MAC_SAT_EN
    exp_s = 32'h7FFF_FFFF;
`else
    exp_s = 32'h7FFE_0000;
`endif
    drive_beat(32'h7FFF_0000, 32'h0002_0000, 1'b1);
    wait_out(ok);
    checks++;
    if (out_sum !== exp_s || out_y !== exp_s || out_d !== 1'b1) begin
      errors++;
      $display("FAIL product_overflow: got s=%h y=%h d=%b want s=y=%h d=1",
               out_sum, out_y, out_d, exp_s);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_acc_overflow();
    bit ok;
    logic [31:0] exp_s, exp_y;
    logic        exp_d;
`ifdef FXP_MAC_SAT_EN
    exp_s = 32'h7FFF_FFFF; exp_y = 32'h7FFF_FFFF; exp_d = 1'b1;
`else
    exp_s = 32'hFFFE_0000; exp_y = 32'h0; exp_d = 1'b0;
`endif
    drive_beat(32'h7FFF_0000, 32'h0001_0000, 1'b0);
    drive_beat(32'h7FFF_0000, 32'h0001_0000, 1'b1);
    wait_out(ok);
    checks++;
    if (out_sum !== exp_s || out_y !== exp_y || out_d !== exp_d || out_count !== 8'd2) begin
      errors++;
      $display("FAIL acc_overflow: got s=%h y=%h d=%b c=%0d want s=%h y=%h d=%b c=2",
               out_sum, out_y, out_d, out_count, exp_s, exp_y, exp_d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    drive_beat(32'h0002_0000, 32'h0002_0000, 1'b1);
    drive_beat(32'hFFFF_0000, 32'h0002_0000, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'h0004_0000 || out_d !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got v=%b s=%h d=%b want v=1 s=00040000 d=1",
               out_valid, out_sum, out_d);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'hFFFE_0000 || out_y !== 32'h0 || out_d !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got v=%b s=%h y=%h d=%b want v=1 s=fffe0000 y=0 d=0",
               out_valid, out_sum, out_y, out_d);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    bit ok;
    out_ready = 1'b0;
    drive_beat(32'h0001_0000, 32'h0002_0000, 1'b1);
    drive_beat(32'h0001_0000, 32'h0003_0000, 1'b0);
    in_a = 32'h0001_0000; in_b = 32'h0005_0000; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 32'h0002_0000 ||
          out_count !== 8'd1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got rdy=%b v=%b s=%h c=%0d want rdy=0 v=1 s=00020000 c=1",
                 i, in_ready, out_valid, out_sum, out_count);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: got out_valid=%b want 0", out_valid);
    end
    wait_out(ok);
    checks++;
    if (out_sum !== 32'h0008_0000 || out_count !== 8'd2 || out_d !== 1'b1) begin
      errors++;
      $display("FAIL stall_second: got s=%h c=%0d d=%b want s=00080000 c=2 d=1",
               out_sum, out_count, out_d);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_dup: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_count_sat();
    bit ok;
    for (int i = 0; i < 299; i++) drive_beat(32'h0, 32'h0001_0000, 1'b0);
    drive_beat(32'h0, 32'h0001_0000, 1'b1);
    wait_out(ok);
    checks++;
    if (out_count !== 8'hFF || out_sum !== 32'h0) begin
      errors++;
      $display("FAIL count_sat: got c=%0d s=%h want c=255 s=0", out_count, out_sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int i = 0; i < 3; i++) drive_beat(32'h0005_0000, 32'h0001_0000, 1'b0);
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 32'h0 || out_count !== 8'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_clear: got v=%b s=%h c=%0d rdy=%b want 0 0 0 1",
               out_valid, out_sum, out_count, in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drive_beat(32'h0001_0000, 32'h0001_0000, 1'b0);
    drive_beat(32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_out(ok);
    checks++;
    if (out_sum !== 32'h0002_0000 || out_count !== 8'd2) begin
      errors++;
      $display("FAIL midreset_vector: got s=%h c=%0d want s=00020000 c=2", out_sum, out_count);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_zero();
    test_product_overflow();
    test_acc_overflow();
    test_back_to_back();
    test_stall();
    test_count_sat();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fxp_mac_stream.md
Name: fxp_mac_stream

Overview:
- Parametrised streaming fixed-point multiply-accumulate engine with fused ReLU. Successor to the single-cycle multiplier/adder/relu primitives.
- Consumes a stream of (a, b) operand pairs and accumulates their truncated products into a dot product.
- When the beat flagged last has been accumulated, emits the activated result, its derivative flag and the pre-activation sum.
- Sits between the weight/activation fetch logic and the layer output buffer of the DNN training datapath.

Parameters:
- WIDTH, 32, total operand/result width, two's complement.
- FRAC, 16, fractional bits (Q(WIDTH-FRAC).FRAC); must satisfy 1 <= FRAC <= WIDTH-2.
- CNT_W, 8, width of the term counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine can accept a beat.
- in_a  in  WIDTH  signed operand a.
- in_b  in  WIDTH  signed operand b.
- in_last  in  1  final term of the current vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_y  out  WIDTH  ReLU(sum).
- out_d  out  1  ReLU derivative: 1 iff sum > 0.
- out_sum  out  WIDTH  pre-activation accumulated sum.
- out_count  out  CNT_W  number of terms in this vector, saturating at all-ones.

Behaviour:
- Reset (async assert, sync release): all valid bits, accumulator, counter and outputs = 0; in_ready = 1 after release.
- Handshake: beat accepted when in_valid && in_ready; result consumed when out_valid && out_ready. Payload and out_valid hold stable while out_valid && !out_ready.
- stall = out_valid && !out_ready. in_ready = !stall. When stall is high, all pipeline registers hold.
- Stage 1 (product register): full 2*WIDTH signed product z; p = {z[2W-1], z[W+FRAC-2:FRAC]}. Registered together with a valid bit and the last flag.
- Stage 2 (accumulator):
  - On a valid stage-1 entry, acc_next = (first ? 0 : acc) + p, where first is set after reset and after every last beat.
  - The counter follows the same rule, restarting at 1.
- Output: if the stage-1 entry is last, acc_next, count, ReLU and d are loaded into the output registers, out_valid = 1, and the accumulator restarts.
  - Otherwise acc := acc_next.
- Latency: last beat accepted in cycle t, out_valid high in cycle t+2. Throughput is 1 beat/cycle when no stall is present.
- ReLU: out_y = sum if sum > 0, else 0; out_d = (sum > 0). A sum of zero gives out_y = 0, out_d = 0.
- Single-beat vector (in_last on the first beat): sum = p, count = 1.
- Output register freed and refilled in the same cycle: out_valid stays 1 and carries the new payload.
- Reset mid-vector: the partial sum is discarded; the next accepted beat starts a new vector.
- Arithmetic wraps modulo 2^WIDTH unless the optional feature below is compiled in.

Optional Feature:
- Macro: FXP_MAC_SAT_EN.
- Defined:
  - The product saturates to the max/min WIDTH-bit value when z exceeds the representable Q range.
  - The accumulator add saturates to 0x7FF..F or 0x800..0 on signed overflow.
  - out_sum is never wrapped.
- Undefined: plain truncation and wrapping as described in Behaviour. No saturation logic is synthesised.

Test Plan:
- Defaults; beats (0x00018000, 0x00020000) then (0xFFFF0000, 0x00040000, last), out_ready = 1 -> out_sum = 0xFFFF0000, out_y = 0, out_d = 0, out_count = 2, out_valid 2 cycles after the last beat.
- Single beat (0x00018000, 0x00020000, last) -> out_sum = out_y = 0x00030000, out_d = 1, out_count = 1.
- (0x7FFF0000, 0x00020000, last) -> out_sum = 0x7FFE0000 without the macro; 0x7FFFFFFF with FXP_MAC_SAT_EN.
- Two beats, each 0x7FFF0000 * 0x00010000, last on the second -> out_sum = 0xFFFE0000 wrapped, out_d = 0; 0x7FFFFFFF with FXP_MAC_SAT_EN.
- Hold out_ready = 0 with a result pending while streaming a second vector -> in_ready = 0, first result held stable; release -> second result correct, no beat lost or duplicated.
- Pulse rst_n low after 3 beats of a vector, then send a 2-beat vector of 1.0*1.0 terms -> out_sum = 0x00020000, out_count = 2.
